// File: rtl/hw_feature_engine_mc.sv
// hw_feature_engine_mc: per-symbol book volumes, bid/(bid+ask) imbalance from a
// sequential restoring divider, and a bucketed sliding-window trade count.
`default_nettype none

module hw_feature_engine_mc #(
  parameter int NUM_SYM       = 4,
  parameter int VOL_W         = 48,
  parameter int FRAC_W        = 10,
  parameter int WIN_BUCKETS   = 8,
  parameter int BUCKET_CYCLES = 128
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ev_valid,
  output logic                             ev_ready,
  input  logic [$clog2(NUM_SYM)-1:0]       ev_sym,
  input  logic [2:0]                       ev_type,
  input  logic [31:0]                      ev_size,
  output logic                             feat_valid,
  output logic [$clog2(NUM_SYM)-1:0]       feat_sym,
  output logic [FRAC_W:0]                  feat_imbalance,
  output logic [8+$clog2(WIN_BUCKETS)-1:0] feat_intensity
);

  localparam int SYM_W = $clog2(NUM_SYM);
  localparam int WIN_W = (WIN_BUCKETS > 1) ? $clog2(WIN_BUCKETS) : 1;
  localparam int INT_W = 8 + $clog2(WIN_BUCKETS);
  localparam int TMR_W = (BUCKET_CYCLES > 1) ? $clog2(BUCKET_CYCLES) : 1;
  localparam int CNT_W = (FRAC_W > 0) ? $clog2(FRAC_W + 1) : 1;
  localparam int DIV_W = VOL_W + FRAC_W + 1;
  localparam int EXT_W = ((VOL_W > 32) ? VOL_W : 32) + 1;
  localparam logic [VOL_W-1:0] VOL_MAX = '1;

  localparam logic [2:0] T_ADD_BID = 3'b000;
  localparam logic [2:0] T_ADD_ASK = 3'b001;
  localparam logic [2:0] T_CAN_BID = 3'b010;
  localparam logic [2:0] T_CAN_ASK = 3'b011;
  localparam logic [2:0] T_TRADE   = 3'b100;

  typedef enum logic [1:0] {IDLE = 2'd0, UPDATE = 2'd1, DIVIDE = 2'd2, OUT = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic [2:0]         type_q, type_d;
  logic [31:0]        size_q, size_d;
  logic [VOL_W-1:0]   bid_q [NUM_SYM];
  logic [VOL_W-1:0]   bid_d [NUM_SYM];
  logic [VOL_W-1:0]   ask_q [NUM_SYM];
  logic [VOL_W-1:0]   ask_d [NUM_SYM];
  logic [7:0]         bkt_q [NUM_SYM][WIN_BUCKETS];
  logic [7:0]         bkt_d [NUM_SYM][WIN_BUCKETS];
  logic [WIN_W-1:0]   head_q, head_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [DIV_W-1:0]   rem_q, rem_d, dsh_q, dsh_d;
  logic [FRAC_W:0]    quo_q, quo_d;
  logic               den_zero_q, den_zero_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               feat_valid_q, feat_valid_d;
  logic [SYM_W-1:0]   feat_sym_q, feat_sym_d;
  logic [FRAC_W:0]    feat_imb_q, feat_imb_d;
  logic [INT_W-1:0]   feat_int_q, feat_int_d;

  logic               wrap, ev_ok, q_bit;
  logic [VOL_W-1:0]   cur_vol, new_vol, new_bid, new_ask;
  logic [EXT_W-1:0]   vol_sum;
  logic [VOL_W:0]     new_den;
  logic [INT_W-1:0]   win_sum;

  assign ev_ready       = (state_q == IDLE) && !rst;
  assign ev_ok          = (ev_type <= T_TRADE) && (32'(ev_sym) < NUM_SYM);
  assign feat_valid     = feat_valid_q;
  assign feat_sym       = feat_sym_q;
  assign feat_imbalance = feat_imb_q;
  assign feat_intensity = feat_int_q;

  always_comb begin
    state_d      = state_q;
    sym_d        = sym_q;
    type_d       = type_q;
    size_d       = size_q;
    bid_d        = bid_q;
    ask_d        = ask_q;
    bkt_d        = bkt_q;
    rem_d        = rem_q;
    dsh_d        = dsh_q;
    quo_d        = quo_q;
    den_zero_d   = den_zero_q;
    cnt_d        = cnt_q;
    feat_valid_d = 1'b0;
    feat_sym_d   = feat_sym_q;
    feat_imb_d   = feat_imb_q;
    feat_int_d   = feat_int_q;
    q_bit        = 1'b0;

    // Free-running bucket timer; the bucket becoming head is emptied for every symbol.
    wrap   = (tmr_q == TMR_W'(BUCKET_CYCLES - 1));
    tmr_d  = wrap ? '0 : TMR_W'(tmr_q + 1'b1);
    head_d = wrap ? WIN_W'(head_q + 1'b1) : head_q;
    if (wrap) begin
      for (int s = 0; s < NUM_SYM; s++) bkt_d[s][head_d] = '0;
    end

    cur_vol = type_q[0] ? ask_q[sym_q] : bid_q[sym_q];
    vol_sum = EXT_W'(cur_vol) + EXT_W'(size_q);
    if (!type_q[1])
      new_vol = (vol_sum > EXT_W'(VOL_MAX)) ? VOL_MAX : VOL_W'(vol_sum);
    else
      new_vol = (EXT_W'(size_q) >= EXT_W'(cur_vol)) ? '0
              : VOL_W'(EXT_W'(cur_vol) - EXT_W'(size_q));
    new_bid = bid_q[sym_q];
    new_ask = ask_q[sym_q];
    if (type_q == T_ADD_BID || type_q == T_CAN_BID) new_bid = new_vol;
    if (type_q == T_ADD_ASK || type_q == T_CAN_ASK) new_ask = new_vol;
    new_den = {1'b0, new_bid} + {1'b0, new_ask};

    win_sum = '0;
    for (int b = 0; b < WIN_BUCKETS; b++) win_sum = win_sum + INT_W'(bkt_q[sym_q][b]);

    case (state_q)
      IDLE: begin
        if (ev_valid && ev_ready && ev_ok) begin
          sym_d   = ev_sym;
          type_d  = ev_type;
          size_d  = ev_size;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        bid_d[sym_q] = new_bid;
        ask_d[sym_q] = new_ask;
        // head_d already points at the freshly cleared bucket when a wrap coincides.
        if (type_q == T_TRADE && bkt_d[sym_q][head_d] != 8'hFF)
          bkt_d[sym_q][head_d] = bkt_d[sym_q][head_d] + 8'd1;
        rem_d      = {1'b0, new_bid, {FRAC_W{1'b0}}};
        dsh_d      = {new_den, {FRAC_W{1'b0}}};
        quo_d      = '0;
        den_zero_d = (new_den == '0);
        cnt_d      = '0;
        state_d    = DIVIDE;
      end
      DIVIDE: begin
        // Quotient is at most 2^FRAC_W, so FRAC_W+1 shifted trial subtractions suffice.
        if (!den_zero_q && rem_q >= dsh_q) begin
          rem_d = rem_q - dsh_q;
          q_bit = 1'b1;
        end
        quo_d = {quo_q[FRAC_W-1:0], q_bit};
        dsh_d = dsh_q >> 1;
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(FRAC_W)) state_d = OUT;
      end
      OUT: begin
        feat_valid_d = 1'b1;
        feat_sym_d   = sym_q;
        feat_imb_d   = quo_q;
        feat_int_d   = win_sum;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sym_q        <= '0;
      type_q       <= '0;
      size_q       <= '0;
      head_q       <= '0;
      tmr_q        <= '0;
      rem_q        <= '0;
      dsh_q        <= '0;
      quo_q        <= '0;
      den_zero_q   <= 1'b0;
      cnt_q        <= '0;
      feat_valid_q <= 1'b0;
      feat_sym_q   <= '0;
      feat_imb_q   <= '0;
      feat_int_q   <= '0;
      for (int s = 0; s < NUM_SYM; s++) begin
        bid_q[s] <= '0;
        ask_q[s] <= '0;
        for (int b = 0; b < WIN_BUCKETS; b++) bkt_q[s][b] <= '0;
      end
    end else begin
      state_q      <= state_d;
      sym_q        <= sym_d;
      type_q       <= type_d;
      size_q       <= size_d;
      head_q       <= head_d;
      tmr_q        <= tmr_d;
      rem_q        <= rem_d;
      dsh_q        <= dsh_d;
      quo_q        <= quo_d;
      den_zero_q   <= den_zero_d;
      cnt_q        <= cnt_d;
      feat_valid_q <= feat_valid_d;
      feat_sym_q   <= feat_sym_d;
      feat_imb_q   <= feat_imb_d;
      feat_int_q   <= feat_int_d;
      bid_q        <= bid_d;
      ask_q        <= ask_d;
      bkt_q        <= bkt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hw_feature_engine_mc.sv
// tb_hw_feature_engine_mc: directed and random events checked against an
// epoch-based reference model of volumes, imbalance and windowed trade counts.
`default_nettype none

module tb_hw_feature_engine_mc;

  localparam int NUM_SYM = 4;
  localparam int VOL_W   = 48;
  localparam int FRAC_W  = 10;
  localparam int WB      = 8;
  localparam int BC      = 128;
  localparam longint unsigned VMAX = (64'd1 << VOL_W) - 64'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ev_valid = 1'b0;
  logic [1:0]  ev_sym = '0;
  logic [2:0]  ev_type = '0;
  logic [31:0] ev_size = '0;
  logic        ev_ready, feat_valid;
  logic [1:0]  feat_sym;
  logic [10:0] feat_imbalance, feat_intensity;

  hw_feature_engine_mc #(
    .NUM_SYM(NUM_SYM), .VOL_W(VOL_W), .FRAC_W(FRAC_W), .WIN_BUCKETS(WB), .BUCKET_CYCLES(BC)
  ) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_sym(ev_sym),
    .ev_type(ev_type), .ev_size(ev_size), .feat_valid(feat_valid), .feat_sym(feat_sym),
    .feat_imbalance(feat_imbalance), .feat_intensity(feat_intensity)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset was released.
  int unsigned ncnt;
  always @(posedge clk or posedge rst) begin
    if (rst) ncnt <= 0;
    else     ncnt <= ncnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct { int sym; int unsigned ep; } trade_t;
  typedef struct { int sym; longint unsigned imb; int unsigned inten; int unsigned when; } exp_t;

  longint unsigned bid_m [NUM_SYM];
  longint unsigned ask_m [NUM_SYM];
  trade_t trades[$];
  exp_t   expq[$];

  // c = edge count at the negedge just before the transfer edge.
  function automatic void model_accept(input int sym, input int typ,
                                       input longint unsigned size, input int unsigned c);
    longint unsigned den, imb;
    int unsigned cur, cnt;
    if (typ > 4) return;
    case (typ)
      0: bid_m[sym] = (bid_m[sym] + size > VMAX) ? VMAX : bid_m[sym] + size;
      1: ask_m[sym] = (ask_m[sym] + size > VMAX) ? VMAX : ask_m[sym] + size;
      2: bid_m[sym] = (size >= bid_m[sym]) ? 0 : bid_m[sym] - size;
      3: ask_m[sym] = (size >= ask_m[sym]) ? 0 : ask_m[sym] - size;
      default: trades.push_back('{sym, (c + 2) / BC});
    endcase
    den = bid_m[sym] + ask_m[sym];
    imb = (den == 0) ? 0 : (bid_m[sym] << FRAC_W) / den;
    cur = (c + FRAC_W + 3) / BC;
    cnt = 0;
    foreach (trades[i]) if (trades[i].sym == sym && cur - trades[i].ep < WB) cnt++;
    expq.push_back('{sym, imb, cnt, c + FRAC_W + 4});
  endfunction

  exp_t       e;
  logic [1:0]  last_sym = '0;
  logic [10:0] last_imb = '0;
  logic [10:0] last_int = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (expq.size() > 0 && ncnt > expq[0].when) begin
        chk("missing_strobe", 0, 1);
        void'(expq.pop_front());
      end
      if (feat_valid) begin
        if (expq.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          e = expq.pop_front();
          chk("strobe_cycle", 64'(ncnt), 64'(e.when));
          chk("feat_sym", 64'(feat_sym), 64'(e.sym));
          chk("feat_imbalance", 64'(feat_imbalance), e.imb);
          chk("feat_intensity", 64'(feat_intensity), 64'(e.inten));
          last_sym = 2'(e.sym);
          last_imb = 11'(e.imb);
          last_int = 11'(e.inten);
        end
      end else begin
        chk("hold_outputs", 64'({feat_sym, feat_imbalance, feat_intensity}),
            64'({last_sym, last_imb, last_int}));
      end
    end
  end

  task automatic do_reset();
    #1;
    rst = 1'b1;
    ev_valid = 1'b0;
    expq.delete();
    trades.delete();
    for (int s = 0; s < NUM_SYM; s++) begin bid_m[s] = 0; ask_m[s] = 0; end
    last_sym = '0; last_imb = '0; last_int = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ev_ready", 64'(ev_ready), 0);
      chk("rst_feat_valid", 64'(feat_valid), 0);
      chk("rst_outputs", 64'({feat_sym, feat_imbalance, feat_intensity}), 0);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(ev_ready), 1);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic issue(input int sym, input int typ, input longint unsigned size);
    int w;
    w = 0;
    ev_valid = 1'b1;
    ev_sym   = 2'(sym);
    ev_type  = 3'(typ);
    ev_size  = 32'(size);
    while (!ev_ready && w < 40) begin @(negedge clk); w++; end
    if (!ev_ready) begin
      chk("ready_timeout", 0, 1);
      ev_valid = 1'b0;
    end else begin
      model_accept(sym, typ, size, ncnt);
      @(negedge clk);
      ev_valid = 1'b0;
      if (typ > 4) chk("drop_stays_idle", 64'(ev_ready), 1);
    end
  endtask

  task automatic expect_strobe(input string tag, input int sym, input int imb, input int inten);
    int w;
    w = 0;
    while (!feat_valid && w < 30) begin @(negedge clk); w++; end
    chk({tag, "_valid"}, 64'(feat_valid), 1);
    chk({tag, "_value"}, 64'({feat_sym, feat_imbalance, feat_intensity}),
        64'({2'(sym), 11'(imb), 11'(inten)}));
    @(negedge clk);
  endtask

  task automatic wait_cnt(input int unsigned target);
    int w;
    w = 0;
    while (ncnt != target && w < 5000) begin @(negedge clk); w++; end
    chk("wait_cnt_reached", 64'(ncnt), 64'(target));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned ep_w, prev_c;
    int s, t, nx, busy;
    longint unsigned sz;

    @(negedge clk);
    do_reset();

    issue(1, 0, 300);  expect_strobe("sym1_bid", 1, 1024, 0);
    issue(2, 0, 100);  expect_strobe("sym2_bid", 2, 1024, 0);
    issue(2, 1, 300);  expect_strobe("sym2_ask", 2, 256, 0);
    issue(0, 4, 0);    expect_strobe("sym0_trade1", 0, 0, 1);
    issue(3, 0, 100);  expect_strobe("sym3_bid", 3, 1024, 0);
    issue(3, 2, 500);  expect_strobe("sym3_cancel", 3, 0, 0);
    issue(3, 4, 0);    expect_strobe("sym3_trade", 3, 0, 1);
    issue(0, 4, 0);    expect_strobe("sym0_trade2", 0, 0, 2);
    issue(0, 4, 0);    expect_strobe("sym0_trade3", 0, 0, 3);
    issue(0, 7, 999);
    repeat (1024) @(negedge clk);
    issue(0, 4, 0);    expect_strobe("sym0_after_idle", 0, 0, 1);

    // Trade whose bucket update lands exactly on a timer wrap.
    while (ncnt % BC != BC - 2) @(negedge clk);
    ep_w = (ncnt + 2) / BC;
    issue(0, 4, 0);    expect_strobe("sym0_wrap_trade", 0, 0, 2);
    wait_cnt((ep_w + WB - 1) * BC + 5);
    issue(0, 4, 0);
    repeat (20) @(negedge clk);

    // Continuous ev_valid: one transfer per FRAC_W+4 cycles.
    nx = 0; busy = 0; prev_c = 0;
    ev_valid = 1'b1; ev_sym = 2'd1; ev_type = 3'd1; ev_size = 32'd77;
    for (int i = 0; i < 60; i++) begin
      if (ev_ready) begin
        model_accept(int'(ev_sym), int'(ev_type), longint'(ev_size), ncnt);
        if (nx > 0) chk("xfer_spacing", 64'(ncnt - prev_c), 64'(FRAC_W + 4));
        prev_c = ncnt;
        nx++;
        @(negedge clk);
        ev_sym = 2'($urandom_range(0, 3)); ev_type = 3'($urandom_range(0, 4));
        ev_size = 32'($urandom_range(0, 500));
      end else begin
        busy++;
        @(negedge clk);
      end
    end
    ev_valid = 1'b0;
    chk("xfer_count", 64'(nx), 5);
    chk("busy_cycles", 64'(busy), 55);
    repeat (20) @(negedge clk);
    chk("queue_drained_burst", 64'(expq.size()), 0);

    // Reset in the middle of a divide.
    issue(2, 0, 777);
    repeat (4) @(negedge clk);
    do_reset();
    issue(0, 1, 50);   expect_strobe("post_rst_ask", 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      s = $urandom_range(0, 3);
      t = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      sz = ($urandom_range(0, 7) == 0) ? longint'($urandom) : longint'($urandom_range(0, 2000));
      issue(s, t, sz);
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    chk("queue_drained_final", 64'(expq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hw_feature_engine_mc.md
HW_FEATURE_ENGINE_MC -- requirements
Module: hw_feature_engine_mc

Interface
REQ-001 Parameter NUM_SYM, default 4: number of independent symbol channels (>=2).
REQ-002 Parameter VOL_W, default 48: per-side volume accumulator width.
REQ-003 Parameter FRAC_W, default 10: imbalance fraction bits, scale 2^FRAC_W.
REQ-004 Parameter WIN_BUCKETS, default 8: buckets in the trade-intensity sliding window (power of 2).
REQ-005 Parameter BUCKET_CYCLES, default 128: clock cycles per window bucket.
REQ-006 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 Port rst, input, 1: reset; asynchronous, active-high.
REQ-008 Port ev_valid, input, 1: market event present.
REQ-009 Port ev_ready, output, 1: block can accept an event; transfer occurs when ev_valid and ev_ready are both high at a rising edge.
REQ-010 Port ev_sym, input, clog2(NUM_SYM): symbol index.
REQ-011 Port ev_type, input, 3: 000 add bid, 001 add ask, 010 cancel bid, 011 cancel ask, 100 trade.
REQ-012 Port ev_size, input, 32: order/cancel size, unsigned.
REQ-013 Port feat_valid, output, 1: one-cycle feature strobe; no backpressure.
REQ-014 Port feat_sym, output, clog2(NUM_SYM): symbol the features belong to.
REQ-015 Port feat_imbalance, output, FRAC_W+1: floor(bid*2^FRAC_W/(bid+ask)), range 0..2^FRAC_W.
REQ-016 Port feat_intensity, output, 8+clog2(WIN_BUCKETS): trade count over the sliding window.

Function
REQ-017 FSM states IDLE, UPDATE, DIVIDE, OUT; ev_ready is high only in IDLE.
REQ-018 IDLE -> UPDATE on transfer; the event is latched; a transfer with ev_type 101-111 or ev_sym >= NUM_SYM is dropped: the FSM stays in IDLE, no state change, no feat_valid.
REQ-019 UPDATE (1 cycle): add = saturating add at 2^VOL_W-1; cancel = subtract, flooring at 0; trade = volumes unchanged, increment the symbol's head-bucket counter (saturating at 255).
REQ-020 DIVIDE: sequential restoring divider, exactly FRAC_W+1 cycles, numerator bid<<FRAC_W, denominator bid+ask (VOL_W+1 bits), using post-UPDATE volumes.
REQ-021 If bid+ask == 0, the quotient SHALL be 0, with the same DIVIDE duration.
REQ-022 OUT (1 cycle): feat_valid=1, feat_sym=latched symbol, feat_imbalance=quotient, feat_intensity=sum of the symbol's WIN_BUCKETS counters; then go to IDLE.
REQ-023 Latency: feat_valid is high in the cycle beginning FRAC_W+3 rising edges after the transfer edge; minimum spacing between transfers is FRAC_W+4 cycles.
REQ-024 feat_sym/feat_imbalance/feat_intensity SHALL hold their last values when feat_valid=0.
REQ-025 A global bucket timer counts 0..BUCKET_CYCLES-1 continuously, independent of FSM state; on wrap, the head index advances modulo WIN_BUCKETS and the new head bucket clears for all symbols.
REQ-026 A trade increment in the same cycle as a bucket advance SHALL land in the new, cleared head bucket (result 1).
REQ-027 Symbol channels SHALL be fully independent; an event on one symbol never alters another symbol's volumes or buckets.

Reset
REQ-028 While rst=1: state IDLE, ev_ready=0, all volumes, buckets, head index and timer 0, feat_valid=0, feat_sym=0, feat_imbalance=0, feat_intensity=0.
REQ-029 ev_ready SHALL rise in the first cycle after rst deasserts; rst during UPDATE/DIVIDE/OUT aborts the operation with no feat_valid.

Verification
REQ-030 Reset; add bid 300 on sym1 -> feat_valid 13 edges later, feat_sym=1, imbalance=1024, intensity=0.
REQ-031 Sym2: add bid 100, then add ask 300 -> second strobe imbalance=256; sym0 state still 0.
REQ-032 Sym3: bid 100, cancel bid 500 -> imbalance=0, bid=0; then a trade with empty book -> imbalance=0, intensity=1.
REQ-033 Three trades on sym0 -> intensities 1,2,3; idle 1024 cycles, trade -> intensity=1; a trade aligned to a bucket wrap -> bucket value 1.
REQ-034 ev_valid held high continuously for 60 cycles -> ev_ready low while busy, exactly one transfer per 14 cycles, no lost or duplicated strobes.
REQ-035 rst pulsed mid-DIVIDE -> no feat_valid, outputs 0; next add ask 50 on sym0 -> imbalance=0.
